// File: rtl/life_collect_if.sv
// Stream/preload/board bundle for the life generation collector.
interface life_collect_if #(parameter int X = 8, parameter int Y = 8);
  logic             in_valid;
  logic             in_first;
  logic             in_bit;
  logic             load;
  logic [X*Y-1:0]   load_data;
  logic [X*Y-1:0]   data;
  logic             gen_done;
  logic [15:0]      gen_count;
  logic             frame_err;

  modport master (output in_valid, in_first, in_bit, load, load_data,
                  input  data, gen_done, gen_count, frame_err);
  modport slave  (input  in_valid, in_first, in_bit, load, load_data,
                  output data, gen_done, gen_count, frame_err);
endinterface

// File: rtl/life_collect.sv
// Collects a scan-order cell stream into an X*Y board word and commits it
// atomically on the last cell; also handles parallel preload and framing errors.
module life_collect #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic          clk,
  input  logic          rst,
  life_collect_if.slave bus
);
  localparam int N  = X * Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_d;

  logic [LOG2X-1:0] x, x_d;
  logic [LOG2Y-1:0] y, y_d;
  logic [N-1:0]     acc, acc_d;
  logic [N-1:0]     data_q;
  logic             gen_done_q, frame_err_q;
  logic [15:0]      gen_count_q;
  logic [IW-1:0]    idx;
  logic             x_wrap, last, commit, restart;

  assign idx    = IW'(y) * IW'(X) + IW'(x);
  assign x_wrap = (x == LOG2X'(X - 1));
  assign last   = x_wrap && (y == LOG2Y'(Y - 1));

  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    acc_d   = acc;
    commit  = 1'b0;
    restart = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_first) begin
        // A first cell is legal anywhere; mid-generation it flags a restart.
        acc_d[0] = bus.in_bit;
        restart  = (state == FILL);
        x_d      = (X == 1) ? '0 : LOG2X'(1);
        y_d      = (X == 1) ? LOG2Y'(1) : '0;
        state_d  = FILL;
        if (N == 1) begin
          commit  = 1'b1;
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end
      end else if (state == FILL) begin
        acc_d[idx] = bus.in_bit;
        if (last) begin
          commit  = 1'b1;
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (x_wrap) begin
          x_d = '0;
          y_d = y + LOG2Y'(1);
        end else begin
          x_d = x + LOG2X'(1);
        end
      end
    end
    if (bus.load) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      commit  = 1'b0;
      restart = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      data_q      <= '0;
      gen_done_q  <= 1'b0;
      gen_count_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state      <= state_d;
      x          <= x_d;
      y          <= y_d;
      gen_done_q <= commit;
      if (bus.load) begin
        data_q      <= bus.load_data;
        gen_count_q <= '0;
        frame_err_q <= 1'b0;
      end else begin
        if (commit) begin
          data_q      <= acc_d;
          gen_count_q <= gen_count_q + 16'd1;
        end
        if (restart) frame_err_q <= 1'b1;
      end
    end
  end

  // Unreceived accumulator bits are never committed, so no reset is needed.
  always_ff @(posedge clk) acc <= acc_d;

  assign bus.data      = data_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.gen_count = gen_count_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_life_collect.sv
// Self-checking bench for life_collect: directed scenarios plus random stream
// against a cell-counting reference model; a 1x1 instance covers count wrap.
module tb_life_collect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  life_collect_if #(.X(8), .Y(8)) bus ();
  life_collect_if #(.X(1), .Y(1)) bus1 ();

  life_collect #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  life_collect #(.X(1), .Y(1), .LOG2X(1), .LOG2Y(1)) u_one (.clk(clk), .rst(rst), .bus(bus1));

  int errs = 0;
  int chks = 0;

  // Reference model: counts cells received in the current generation.
  logic [63:0] m_data, m_acc;
  logic        m_done, m_err;
  logic [15:0] m_cnt;
  int          m_pos;

  function automatic logic [81:0] obs();
    return {bus.data, bus.gen_done, bus.gen_count, bus.frame_err};
  endfunction
  function automatic logic [81:0] expv();
    return {m_data, m_done, m_cnt, m_err};
  endfunction
  function automatic logic cb(input int i);
    return logic'(((i % 8) ^ (i / 8)) & 1);
  endfunction

  task automatic step(input logic r, v, f, b, ld, input logic [63:0] ldd);
    rst = r; bus.in_valid = v; bus.in_first = f; bus.in_bit = b;
    bus.load = ld; bus.load_data = ldd;
    @(posedge clk);
    if (r) begin
      m_data = '0; m_done = 0; m_cnt = '0; m_err = 0; m_pos = -1;
    end else if (ld) begin
      m_data = ldd; m_done = 0; m_cnt = '0; m_err = 0; m_pos = -1;
    end else begin
      m_done = 0;
      if (v && f) begin
        if (m_pos >= 0) m_err = 1;
        m_acc = '0; m_acc[0] = b; m_pos = 1;
      end else if (v && m_pos >= 0) begin
        m_acc[m_pos] = b; m_pos++;
      end
      if (m_pos == 64) begin
        m_data = m_acc; m_done = 1; m_cnt++; m_pos = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, '0);
    step(1, 1, 1, 1, 1, 64'hFFFF);
    chks++;
    if (obs() !== 82'd0) begin errs++; $display("FAIL reset got %h want 0", obs()); end
    chks++;
    if ({bus1.data, bus1.gen_done, bus1.gen_count, bus1.frame_err} !== 19'd0) begin
      errs++; $display("FAIL reset_1x1 got cnt %0d want 0", bus1.gen_count);
    end
  endtask

  task automatic test_checker();
    logic [63:0] cbw;
    for (int i = 0; i < 64; i++) cbw[i] = cb(i);
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i == 0, cb(i), 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL checker i=%0d got %h want %h", i, obs(), expv()); end
    end
    chks++;
    if ({bus.data, bus.gen_done, bus.gen_count} !== {cbw, 1'b1, 16'd1}) begin
      errs++; $display("FAIL checker_commit got %h/%b/%0d want %h/1/1", bus.data, bus.gen_done, bus.gen_count, cbw);
    end
    step(0, 0, 0, 0, 0, '0);
    chks++;
    if (bus.gen_done !== 1'b0) begin errs++; $display("FAIL checker_pulse got %b want 0", bus.gen_done); end
  endtask

  task automatic test_gaps();
    logic [63:0] cbw;
    for (int i = 0; i < 64; i++) cbw[i] = cb(i);
    step(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 127; k++) begin
      step(0, (k % 2) == 0, k == 0, cb(k / 2), 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL gaps k=%0d got %h want %h", k, obs(), expv()); end
    end
    chks++;
    if ({bus.data, bus.gen_done, bus.gen_count} !== {cbw, 1'b1, 16'd1}) begin
      errs++; $display("FAIL gaps_commit got %h/%b/%0d want %h/1/1", bus.data, bus.gen_done, bus.gen_count, cbw);
    end
  endtask

  task automatic test_blinker();
    step(0, 0, 0, 0, 1, 64'h1C00);
    chks++;
    if ({bus.data, bus.gen_done, bus.gen_count} !== {64'h1C00, 1'b0, 16'd0}) begin
      errs++; $display("FAIL blinker_load got %h/%b/%0d want 1c00/0/0", bus.data, bus.gen_done, bus.gen_count);
    end
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i == 0, 0, 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL blinker i=%0d got %h want %h", i, obs(), expv()); end
    end
    chks++;
    if ({bus.data, bus.gen_count} !== {64'h0, 16'd1}) begin
      errs++; $display("FAIL blinker_commit got %h/%0d want 0/1", bus.data, bus.gen_count);
    end
  endtask

  task automatic test_restart();
    logic [63:0] ld;
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(0, 1, i == 0, 1'($urandom), 0, '0);
    step(0, 1, 1, 1, 0, '0);
    chks++;
    if ({bus.frame_err, bus.data} !== {1'b1, 64'h0}) begin
      errs++; $display("FAIL restart_err got %b/%h want 1/0", bus.frame_err, bus.data);
    end
    for (int i = 1; i < 64; i++) begin
      step(0, 1, 0, 1, 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL restart i=%0d got %h want %h", i, obs(), expv()); end
    end
    chks++;
    if ({bus.data, bus.gen_count, bus.frame_err} !== {64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 1'b1}) begin
      errs++; $display("FAIL restart_commit got %h/%0d/%b want all-ones/1/1", bus.data, bus.gen_count, bus.frame_err);
    end
    ld = {$urandom, $urandom};
    step(0, 0, 0, 0, 1, ld);
    chks++;
    if ({bus.frame_err, bus.data} !== {1'b0, ld}) begin
      errs++; $display("FAIL restart_load got %b/%h want 0/%h", bus.frame_err, bus.data, ld);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1, 64'hDEAD_BEEF);
    for (int i = 0; i < 30; i++) step(0, 1, i == 0, 1'($urandom), 0, '0);
    step(1, 1, 0, 1, 0, '0);
    chks++;
    if (obs() !== 82'd0) begin errs++; $display("FAIL reset_mid got %h want 0", obs()); end
    for (int i = 0; i < 70; i++) step(0, 1, 0, 1, 0, '0);
    chks++;
    if (obs() !== 82'd0) begin errs++; $display("FAIL reset_mid_ignore got %h want 0", obs()); end
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i == 0, 1'($urandom), 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL reset_mid i=%0d got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 192; i++) begin
      step(0, 1, (i % 64) == 0, 1'($urandom), 0, '0);
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL b2b i=%0d got %h want %h", i, obs(), expv()); end
    end
    chks++;
    if (bus.gen_count !== 16'd3) begin errs++; $display("FAIL b2b_count got %0d want 3", bus.gen_count); end
  endtask

  task automatic test_random();
    logic v, f, r, ld;
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom % 4) != 0;
      f  = v && ((m_pos < 0) ? ($urandom % 2 == 0) : ($urandom % 150 == 0));
      ld = ($urandom % 400) == 0;
      r  = ($urandom % 900) == 0;
      step(r, v, f, 1'($urandom), ld, {$urandom, $urandom});
      chks++;
      if (obs() !== expv()) begin errs++; $display("FAIL random i=%0d got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_wrap();
    logic b;
    logic [15:0] want;
    for (int i = 0; i < 65537; i++) begin
      b = 1'($urandom);
      bus1.in_valid = 1; bus1.in_first = 1; bus1.in_bit = b;
      @(posedge clk); #1;
      want = 16'(i + 1);
      if (i < 4 || i > 65530) begin
        chks++;
        if ({bus1.data, bus1.gen_done, bus1.gen_count, bus1.frame_err} !== {b, 1'b1, want, 1'b0}) begin
          errs++; $display("FAIL wrap i=%0d got %b/%b/%0d/%b want %b/1/%0d/0",
                           i, bus1.data, bus1.gen_done, bus1.gen_count, bus1.frame_err, b, want);
        end
      end
    end
    bus1.in_valid = 0; bus1.in_first = 0;
    @(posedge clk); #1;
    chks++;
    if ({bus1.gen_done, bus1.gen_count} !== {1'b0, 16'd1}) begin
      errs++; $display("FAIL wrap_idle got %b/%0d want 0/1", bus1.gen_done, bus1.gen_count);
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_first = 0; bus.in_bit = 0; bus.load = 0; bus.load_data = '0;
    bus1.in_valid = 0; bus1.in_first = 0; bus1.in_bit = 0; bus1.load = 0; bus1.load_data = '0;
    m_data = '0; m_acc = '0; m_done = 0; m_err = 0; m_cnt = '0; m_pos = -1;
    test_reset();
    test_checker();
    test_gaps();
    test_blinker();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
